// File: rtl/compare_tally_pkg.sv
// Shared types and helpers for the comparator tally stage: FSM state encoding,
// winner codes and the one-hot flag check.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  // Exactly one of the three comparator flags is set.
  function automatic logic onehot3(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/compare_tally_if.sv
// Comparator result channel: three flags qualified by in_valid, accepted on in_ready.
// Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
// the master holds flags stable while in_valid is high, and in_ready never depends on in_valid.
interface compare_tally_if;
  logic in_valid;
  logic in_ready;
  logic a_is_greater;
  logic b_is_greater;
  logic are_equal;

  modport master (
    output in_valid, a_is_greater, b_is_greater, are_equal,
    input  in_ready
  );

  modport slave (
    input  in_valid, a_is_greater, b_is_greater, are_equal,
    output in_ready
  );
endinterface

// File: rtl/compare_tally_counter.sv
// Tally counter with synchronous clear and increment enable; optionally holds at
// all-ones instead of wrapping.
module tally_counter #(
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic at_max;
  assign at_max = SATURATE && (count == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/compare_tally.sv
// Match tally stage behind the 4-bit magnitude comparator: counts A wins, B wins
// and ties per match and declares a winner when one side reaches WIN_TARGET.
module compare_tally
  import compare_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int WIN_TARGET = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  compare_tally_if.slave   cmp,
  output logic [CNT_W-1:0] a_wins,
  output logic [CNT_W-1:0] b_wins,
  output logic [CNT_W-1:0] ties,
  output logic [1:0]       winner,
  output logic             done,
  output logic             busy,
  output logic             flag_err,
  output state_t           state_dbg
);

  localparam logic [CNT_W-1:0] TARGET_M1 = CNT_W'(WIN_TARGET - 1);

  state_t     state_q, state_d;
  logic       ready_q;
  logic [2:0] flags;
  logic       accept;
  logic       inc_a, inc_b, inc_t, clr, set_err;
  logic [1:0] winner_d;
  logic       done_d;

  assign flags         = {cmp.a_is_greater, cmp.b_is_greater, cmp.are_equal};
  // start outranks a sample presented in the same cycle.
  assign accept        = cmp.in_valid && ready_q && !start;
  assign cmp.in_ready  = ready_q;
  assign state_dbg     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    inc_a    = 1'b0;
    inc_b    = 1'b0;
    inc_t    = 1'b0;
    clr      = 1'b0;
    set_err  = 1'b0;
    winner_d = winner;
    done_d   = done;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          clr      = 1'b1;
          winner_d = WIN_NONE;
          done_d   = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          clr      = 1'b1;
          winner_d = WIN_NONE;
        end else if (accept) begin
          if (!onehot3(flags)) begin
            set_err = 1'b1;
          end else if (flags == 3'b100) begin
            inc_a = 1'b1;
            if (a_wins == TARGET_M1) begin
              state_d  = DONE;
              winner_d = WIN_A;
              done_d   = 1'b1;
            end
          end else if (flags == 3'b010) begin
            inc_b = 1'b1;
            if (b_wins == TARGET_M1) begin
              state_d  = DONE;
              winner_d = WIN_B;
              done_d   = 1'b1;
            end
          end else begin
            inc_t = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state decode so they line up with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      winner   <= WIN_NONE;
      flag_err <= 1'b0;
    end else begin
      ready_q  <= (state_d == RUN);
      busy     <= (state_d == RUN);
      done     <= done_d;
      winner   <= winner_d;
      flag_err <= clr ? 1'b0 : (flag_err | set_err);
    end
  end

  tally_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_a_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_a), .count(a_wins)
  );

  tally_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_b_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_b), .count(b_wins)
  );

  tally_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_t_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_t), .count(ties)
  );

endmodule

// File: tb/tb_compare_tally.sv
// Bench for compare_tally (CNT_W=4, WIN_TARGET=3): directed plan steps followed by
// random traffic, all checked against a match-level reference model.
module tb_compare_tally;
  import compare_pkg::*;

  localparam int CNT_W      = 4;
  localparam int WIN_TARGET = 3;
  localparam int TIE_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] a_wins, b_wins, ties;
  logic [1:0]       winner;
  logic             done, busy, flag_err;
  state_t           state_dbg;

  compare_tally_if cmp ();

  compare_tally #(.CNT_W(CNT_W), .WIN_TARGET(WIN_TARGET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp(cmp),
    .a_wins(a_wins), .b_wins(b_wins), .ties(ties), .winner(winner),
    .done(done), .busy(busy), .flag_err(flag_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // reference model: match-level bookkeeping
  state_t m_phase;
  int     m_a, m_b, m_t, m_win;
  bit     m_err, m_done;

  function automatic void model_reset();
    m_phase = IDLE; m_a = 0; m_b = 0; m_t = 0; m_win = 0; m_err = 0; m_done = 0;
  endfunction

  function automatic void model_clock(bit st, bit v, logic [2:0] f);
    if (st) begin
      m_phase = RUN; m_a = 0; m_b = 0; m_t = 0; m_win = 0; m_err = 0; m_done = 0;
    end else if (m_phase == RUN && v) begin
      case (f)
        3'b100: begin
          m_a++;
          if (m_a == WIN_TARGET) begin m_phase = DONE; m_win = 1; m_done = 1; end
        end
        3'b010: begin
          m_b++;
          if (m_b == WIN_TARGET) begin m_phase = DONE; m_win = 2; m_done = 1; end
        end
        3'b001:  if (m_t < TIE_MAX) m_t++;
        default: m_err = 1;
      endcase
    end
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit run;
    run = (m_phase == RUN);
    chk({tag, ".a_wins"},   32'(a_wins),    32'(m_a));
    chk({tag, ".b_wins"},   32'(b_wins),    32'(m_b));
    chk({tag, ".ties"},     32'(ties),      32'(m_t));
    chk({tag, ".winner"},   32'(winner),    32'(m_win));
    chk({tag, ".done"},     32'(done),      32'(m_done));
    chk({tag, ".busy"},     32'(busy),      32'(run));
    chk({tag, ".in_ready"}, 32'(cmp.in_ready), 32'(run));
    chk({tag, ".flag_err"}, 32'(flag_err),  32'(m_err));
    chk({tag, ".state"},    32'(state_dbg), 32'(m_phase));
  endtask

  // driver: present one cycle of inputs at the falling edge, check just after the rising edge
  task automatic step(input string tag, input bit st, input bit v, input logic [2:0] f);
    @(negedge clk);
    start            = st;
    cmp.in_valid     = v;
    cmp.a_is_greater = f[2];
    cmp.b_is_greater = f[1];
    cmp.are_equal    = f[0];
    @(posedge clk);
    model_clock(st, v, f);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] f;
    int         r;
    start = 1'b0; cmp.in_valid = 1'b1;
    cmp.a_is_greater = 1'b1; cmp.b_is_greater = 1'b0; cmp.are_equal = 1'b0;
    rst_n = 1'b0;
    model_reset();

    // reset held with a valid A sample on the inputs
    repeat (2) @(posedge clk);
    #1 check_all("reset_hold");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step("idle_no_start", 1'b0, 1'b1, 3'b100);

    // normal match to an A win
    step("start1", 1'b1, 1'b0, 3'b000);
    step("m_a1",  1'b0, 1'b1, 3'b100);
    step("m_a2",  1'b0, 1'b1, 3'b100);
    step("m_b1",  1'b0, 1'b1, 3'b010);
    step("m_t1",  1'b0, 1'b1, 3'b001);
    step("m_a3",  1'b0, 1'b1, 3'b100);
    step("done_ignores", 1'b0, 1'b1, 3'b010);
    step("done_start_valid", 1'b1, 1'b1, 3'b100);

    // malformed flags
    step("bad_110", 1'b0, 1'b1, 3'b110);
    step("bad_000", 1'b0, 1'b1, 3'b000);
    step("after_bad", 1'b0, 1'b1, 3'b010);

    // tie saturation
    for (int i = 0; i < 20; i++) step("tie_sat", 1'b0, 1'b1, 3'b001);

    // restart priority over a same-cycle sample
    step("rs_a1", 1'b0, 1'b1, 3'b100);
    step("rs_a2", 1'b0, 1'b1, 3'b100);
    step("restart", 1'b1, 1'b1, 3'b100);

    // async reset between edges
    step("ar_a1", 1'b0, 1'b1, 3'b100);
    step("ar_a2", 1'b0, 1'b1, 3'b100);
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step("post_reset_idle", 1'b0, 1'b1, 3'b100);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: f = 3'b100;
        3, 4, 5: f = 3'b010;
        6, 7:    f = 3'b001;
        8:       f = 3'($urandom_range(0, 7));
        default: f = 3'b000;
      endcase
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
